shift_delay_line: RTL and testbench

SHIFT_DELAY_LINE -- requirements
Module: shift_delay_line

---
 rtl/sc_pkg.sv | 17 +
 rtl/shift_delay_line_sr_stage.sv | 24 ++
 rtl/shift_delay_line.sv | 65 ++++++
 tb/tb_shift_delay_line.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared helpers for the codebase: constant-foldable math used to size ports.
package sc_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/shift_delay_line_sr_stage.sv
// One storage stage of the delay line: WIDTH-bit register with async reset,
// synchronous clear (wins over enable) and load enable.
module sr_stage #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/shift_delay_line.sv
// Programmable-tap shift delay line: DEPTH stages, tap chosen by delay_sel,
// with a saturating fill counter that qualifies the selected tap.
module shift_delay_line
   import sc_pkg::*;
#(
   parameter int  WIDTH = 1,
   parameter int  DEPTH = 8,
   localparam int SELW  = clog2(DEPTH),
   localparam int CNTW  = clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clear,
   input  logic [SELW-1:0] delay_sel,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic            valid,
   output logic [CNTW-1:0] fill_count
);

   localparam logic [SELW-1:0] MAX_SEL = SELW'(DEPTH - 1);
   localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);

   logic [WIDTH-1:0] stage [DEPTH];
   logic [SELW-1:0]  eff_sel;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] d;
         if (gi == 0) begin : g_head
            assign d = data_in;
         end else begin : g_tail
            assign d = stage[gi-1];
         end
         sr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .en    (en),
            .d     (d),
            .q     (stage[gi])
         );
      end
   endgenerate

   // Out-of-range selects (possible when DEPTH is not a power of two) clamp to the last stage.
   always_comb begin
      eff_sel  = (delay_sel > MAX_SEL) ? MAX_SEL : delay_sel;
      data_out = stage[eff_sel];
      valid    = (fill_count > CNTW'(eff_sel));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_count <= '0;
      end else if (clear) begin
         fill_count <= '0;
      end else if (en && (fill_count != FULL)) begin
         fill_count <= fill_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_shift_delay_line.sv
// Bench for shift_delay_line: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a sample-history model.
module tb_shift_delay_line;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       clear;
   logic [3:0] data_in;
   logic [2:0] sel8;
   logic [2:0] sel5;
   logic [3:0] out8;
   logic [3:0] out5;
   logic       val8;
   logic       val5;
   logic [3:0] fc8;
   logic [2:0] fc5;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   shift_delay_line #(.WIDTH(4), .DEPTH(8)) u8 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clear      (clear),
      .delay_sel  (sel8),
      .data_in    (data_in),
      .data_out   (out8),
      .valid      (val8),
      .fill_count (fc8)
   );

   shift_delay_line #(.WIDTH(4), .DEPTH(5)) u5 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clear      (clear),
      .delay_sel  (sel5),
      .data_in    (data_in),
      .data_out   (out5),
      .valid      (val5),
      .fill_count (fc5)
   );

   // Model: every sample accepted since the last flush, in arrival order.
   logic [3:0] hist [256];
   int         n_acc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_acc <= 0;
      end else if (clear) begin
         n_acc <= 0;
      end else if (en) begin
         hist[n_acc % 256] <= data_in;
         n_acc <= n_acc + 1;
      end
   end

   function automatic int eff(input int depth, input int sel);
      return (sel > depth - 1) ? depth - 1 : sel;
   endfunction

   // Sample that arrived eff+1 accepted edges ago, or 0 if none since flush.
   function automatic int exp_out(input int depth, input int sel);
      int e;
      e = eff(depth, sel);
      return (e < n_acc) ? int'(hist[(n_acc - 1 - e) % 256]) : 0;
   endfunction

   function automatic int exp_fill(input int depth);
      return (n_acc < depth) ? n_acc : depth;
   endfunction

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("m8_data", int'(out8), exp_out(8, int'(sel8)));
         chk("m8_valid", int'(val8), int'(n_acc > eff(8, int'(sel8))));
         chk("m8_fill", int'(fc8), exp_fill(8));
         chk("m5_data", int'(out5), exp_out(5, int'(sel5)));
         chk("m5_valid", int'(val5), int'(n_acc > eff(5, int'(sel5))));
         chk("m5_fill", int'(fc5), exp_fill(5));
      end
   end

   // One clock edge; returns 3 ns after it so outputs of that edge are settled.
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clear = 1'b0; data_in = '0; sel8 = 3'd2; sel5 = 3'd2;
      cmp_on = 1'b1;
      tick();
      chk("reset_data", int'(out8), 0);
      chk("reset_valid", int'(val8), 0);
      chk("reset_fill", int'(fc8), 0);
      rst = 1'b0;

      // Latency: 1,2,3 with tap 2
      en = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         data_in = 4'(k);
         tick();
         if (k == 2) chk("lat_valid_early", int'(val8), 0);
      end
      chk("lat_data", int'(out8), 1);
      chk("lat_valid", int'(val8), 1);
      chk("lat_fill", int'(fc8), 3);
      $display("latency scenario done");

      // Stall
      en = 1'b0; data_in = 4'hE;
      for (int k = 0; k < 5; k++) tick();
      chk("stall_data", int'(out8), 1);
      chk("stall_fill", int'(fc8), 3);
      en = 1'b1; data_in = 4'd4;
      tick();
      chk("resume_data", int'(out8), 2);
      $display("stall scenario done");

      // Tap change with fill_count=4 (stages hold 4,3,2,1)
      en = 1'b0;
      sel8 = 3'd1; #1;
      chk("tap1_valid", int'(val8), 1);
      sel8 = 3'd5; #1;
      chk("tap5_valid", int'(val8), 0);
      sel8 = 3'd1; #1;
      chk("tapback_valid", int'(val8), 1);
      chk("tapback_data", int'(out8), 3);
      $display("tap change scenario done");

      // Saturation: ten samples 10..19 (4-bit: 10..15,0..3)
      sel8 = 3'd7; sel5 = 3'd7; en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         data_in = 4'(10 + k);
         tick();
      end
      en = 1'b0;
      chk("sat_fill", int'(fc8), 8);
      chk("sat_valid", int'(val8), 1);
      chk("sat_data", int'(out8), 12);
      chk("sat5_sel7_data", int'(out5), 15);
      chk("sat5_sel7_valid", int'(val5), 1);
      chk("sat5_fill", int'(fc5), 5);
      sel5 = 3'd4; #1;
      chk("sat5_sel4_data", int'(out5), 15);
      $display("saturation scenario done");

      // Clear priority over enable
      clear = 1'b1; en = 1'b1; data_in = 4'hF;
      tick();
      clear = 1'b0; en = 1'b0;
      chk("clr_fill", int'(fc8), 0);
      chk("clr_valid", int'(val8), 0);
      sel8 = 3'd0; #1;
      chk("clr_stage0", int'(out8), 0);
      chk("clr5_fill", int'(fc5), 0);
      $display("clear scenario done");

      // Async reset mid-stream
      sel8 = 3'd2; en = 1'b1;
      for (int k = 5; k <= 8; k++) begin
         data_in = 4'(k);
         tick();
      end
      chk("pre_rst_data", int'(out8), 6);
      rst = 1'b1; #1;
      chk("arst_data", int'(out8), 0);
      chk("arst_valid", int'(val8), 0);
      chk("arst_fill", int'(fc8), 0);
      tick();
      rst = 1'b0;
      for (int k = 9; k <= 11; k++) begin
         data_in = 4'(k);
         tick();
         if (k == 10) chk("post_rst_valid_early", int'(val8), 0);
      end
      chk("post_rst_data", int'(out8), 9);
      chk("post_rst_fill", int'(fc8), 3);
      $display("async reset scenario done");

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         en      = ($urandom_range(0, 3) != 0);
         clear   = ($urandom_range(0, 39) == 0);
         data_in = 4'($urandom);
         sel8    = 3'($urandom);
         sel5    = 3'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
      end
      tick();
      cmp_on = 1'b0;
      $display("random phase done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
